// File: rtl/issue_rat_freelist_checkpoint_bank_mp.sv
// Free-list checkpoint bank for one issue-stage RAT checkpoint slot.
// PRFs released while the checkpoint (tagged by its FGR) is open are
// captured in a small FIFO. On commit they are drained back to the free
// list. On abandon they are discarded.
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   alloc_i_en/alloc_i_fgr     open the bank for a new checkpoint (FREE only)
//   push_i_wen/push_i_prf      WRITE_PORTS push lanes, packed in ascending lane order
//   seal_i_en                  close the checkpoint to further pushes (OPEN only)
//   commit_i_en/commit_i_fgr   commit request, FGR-matched (SEALED only)
//   abandon_i_en/abandon_i_fgr flush request, FGR-matched (any non-FREE state)
//   pop_i_ren                  pop head entry (DRAIN only)
//   tag_o_*                    state decodes, sticky abandoned flag
//   fgr_o                      FGR held by the bank
//   fifo_o_*                   head entry, occupancy, full/empty, sticky overflow
module issue_rat_freelist_checkpoint_bank_mp #(
    parameter int unsigned PRF_WIDTH       = 6,
    parameter int unsigned FGR_WIDTH       = 3,
    parameter int unsigned BANK_DEPTH_LOG2 = 2,
    parameter int unsigned WRITE_PORTS     = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             alloc_i_en,
    input  logic [FGR_WIDTH-1:0]             alloc_i_fgr,
    input  logic [WRITE_PORTS-1:0]           push_i_wen,
    input  logic [WRITE_PORTS*PRF_WIDTH-1:0] push_i_prf,
    input  logic                             seal_i_en,
    input  logic                             commit_i_en,
    input  logic [FGR_WIDTH-1:0]             commit_i_fgr,
    input  logic                             abandon_i_en,
    input  logic [FGR_WIDTH-1:0]             abandon_i_fgr,
    input  logic                             pop_i_ren,
    output logic                             tag_o_valid,
    output logic                             tag_o_open,
    output logic                             tag_o_sealed,
    output logic                             tag_o_drain,
    output logic                             tag_o_abandoned,
    output logic [FGR_WIDTH-1:0]             fgr_o,
    output logic [PRF_WIDTH-1:0]             fifo_o_prf,
    output logic [BANK_DEPTH_LOG2:0]         fifo_o_count,
    output logic                             fifo_o_full,
    output logic                             fifo_o_empty,
    output logic                             fifo_o_overflow
);

    localparam int unsigned DEPTH = 1 << BANK_DEPTH_LOG2;
    localparam int unsigned CW    = BANK_DEPTH_LOG2 + 1;
    localparam int unsigned IW    = BANK_DEPTH_LOG2;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {StFree, StOpen, StSealed, StDrain} state_e;

    state_e               r_state, w_state_d;
    logic [FGR_WIDTH-1:0] r_fgr, w_fgr_d;
    logic                 r_abandoned, w_abandoned_d;
    logic                 r_overflow, w_overflow_d;
    logic [CW-1:0]        r_wptr, w_wptr_d;
    logic [CW-1:0]        r_rptr, w_rptr_d;
    logic [PRF_WIDTH-1:0] r_ram [DEPTH];

    logic [CW-1:0]          w_count;
    logic [CW-1:0]          w_space;
    logic                   w_abandon_hit;
    logic                   w_commit_hit;
    logic                   w_push_ok;
    logic [WRITE_PORTS-1:0] w_wr_en;
    logic [IW-1:0]          w_wr_idx [WRITE_PORTS];
    logic [CW-1:0]          w_n_acc;
    logic                   w_push_drop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_count       = r_wptr - r_rptr;
    assign w_space       = DEPTH_C - w_count;
    assign w_abandon_hit = abandon_i_en && (r_state != StFree) && (abandon_i_fgr == r_fgr);
    assign w_commit_hit  = commit_i_en && (r_state == StSealed) && (commit_i_fgr == r_fgr);
    assign w_push_ok     = (r_state == StOpen) && !w_abandon_hit;

    // Pack active lanes into consecutive slots; lanes past the free space are dropped.
    always_comb begin
        logic [CW-1:0] n;
        n           = '0;
        w_wr_en     = '0;
        w_push_drop = 1'b0;
        for (int k = 0; k < WRITE_PORTS; k++) begin
            w_wr_idx[k] = r_wptr[IW-1:0] + n[IW-1:0];
            if (w_push_ok && push_i_wen[k]) begin
                if (n < w_space) begin
                    w_wr_en[k] = 1'b1;
                    n          = n + CW'(1);
                end else begin
                    w_push_drop = 1'b1;
                end
            end
        end
        w_n_acc = n;
    end

    always_comb begin
        w_state_d     = r_state;
        w_fgr_d       = r_fgr;
        w_abandoned_d = r_abandoned;
        w_overflow_d  = r_overflow;
        w_wptr_d      = r_wptr;
        w_rptr_d      = r_rptr;
        if (w_abandon_hit) begin
            w_state_d     = StFree;
            w_wptr_d      = '0;
            w_rptr_d      = '0;
            w_abandoned_d = 1'b1;
        end else begin
            unique case (r_state)
                StFree: begin
                    if (alloc_i_en) begin
                        w_state_d     = StOpen;
                        w_fgr_d       = alloc_i_fgr;
                        w_wptr_d      = '0;
                        w_rptr_d      = '0;
                        w_abandoned_d = 1'b0;
                        w_overflow_d  = 1'b0;
                    end
                end
                StOpen: begin
                    w_wptr_d = r_wptr + w_n_acc;
                    if (w_push_drop) w_overflow_d = 1'b1;
                    if (seal_i_en) w_state_d = StSealed;
                end
                StSealed: begin
                    if (w_commit_hit) w_state_d = (w_count == '0) ? StFree : StDrain;
                end
                StDrain: begin
                    if (pop_i_ren && (w_count != '0)) begin
                        w_rptr_d = r_rptr + CW'(1);
                        if (w_count == CW'(1)) w_state_d = StFree;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= StFree;
            r_fgr       <= '0;
            r_abandoned <= 1'b0;
            r_overflow  <= 1'b0;
            r_wptr      <= '0;
            r_rptr      <= '0;
        end else begin
            r_state     <= w_state_d;
            r_fgr       <= w_fgr_d;
            r_abandoned <= w_abandoned_d;
            r_overflow  <= w_overflow_d;
            r_wptr      <= w_wptr_d;
            r_rptr      <= w_rptr_d;
        end
    end

    // Storage is deliberately not reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        for (int k = 0; k < WRITE_PORTS; k++) begin
            if (w_wr_en[k]) r_ram[w_wr_idx[k]] <= push_i_prf[k*PRF_WIDTH +: PRF_WIDTH];
        end
    end

    assign tag_o_valid     = (r_state != StFree);
    assign tag_o_open      = (r_state == StOpen);
    assign tag_o_sealed    = (r_state == StSealed);
    assign tag_o_drain     = (r_state == StDrain);
    assign tag_o_abandoned = r_abandoned;
    assign fgr_o           = r_fgr;
    assign fifo_o_count    = w_count;
    assign fifo_o_full     = (w_count == DEPTH_C);
    assign fifo_o_empty    = (w_count == '0);
    assign fifo_o_overflow = r_overflow;
    assign fifo_o_prf      = (w_count == '0) ? '0 : r_ram[r_rptr[IW-1:0]];

endmodule

// File: tb/tb_issue_rat_freelist_checkpoint_bank_mp.sv
// Self-checking bench for issue_rat_freelist_checkpoint_bank_mp.
// A queue-based model of the checkpoint bank is stepped alongside the DUT
// and every output is compared on each falling edge; directed sequences add
// literal expectations, then a long randomized run follows.
module tb_issue_rat_freelist_checkpoint_bank_mp;

    localparam int PW    = 6;
    localparam int FW    = 3;
    localparam int DL    = 2;
    localparam int WP    = 2;
    localparam int DEPTH = 1 << DL;
    localparam int PRFW  = WP * PW;

    localparam int M_FREE   = 0;
    localparam int M_OPEN   = 1;
    localparam int M_SEALED = 2;
    localparam int M_DRAIN  = 3;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            alloc_i_en;
    logic [FW-1:0]   alloc_i_fgr;
    logic [WP-1:0]   push_i_wen;
    logic [PRFW-1:0] push_i_prf;
    logic            seal_i_en;
    logic            commit_i_en;
    logic [FW-1:0]   commit_i_fgr;
    logic            abandon_i_en;
    logic [FW-1:0]   abandon_i_fgr;
    logic            pop_i_ren;
    logic            tag_o_valid, tag_o_open, tag_o_sealed, tag_o_drain, tag_o_abandoned;
    logic [FW-1:0]   fgr_o;
    logic [PW-1:0]   fifo_o_prf;
    logic [DL:0]     fifo_o_count;
    logic            fifo_o_full, fifo_o_empty, fifo_o_overflow;

    issue_rat_freelist_checkpoint_bank_mp #(
        .PRF_WIDTH      (PW),
        .FGR_WIDTH      (FW),
        .BANK_DEPTH_LOG2(DL),
        .WRITE_PORTS    (WP)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .alloc_i_en     (alloc_i_en),
        .alloc_i_fgr    (alloc_i_fgr),
        .push_i_wen     (push_i_wen),
        .push_i_prf     (push_i_prf),
        .seal_i_en      (seal_i_en),
        .commit_i_en    (commit_i_en),
        .commit_i_fgr   (commit_i_fgr),
        .abandon_i_en   (abandon_i_en),
        .abandon_i_fgr  (abandon_i_fgr),
        .pop_i_ren      (pop_i_ren),
        .tag_o_valid    (tag_o_valid),
        .tag_o_open     (tag_o_open),
        .tag_o_sealed   (tag_o_sealed),
        .tag_o_drain    (tag_o_drain),
        .tag_o_abandoned(tag_o_abandoned),
        .fgr_o          (fgr_o),
        .fifo_o_prf     (fifo_o_prf),
        .fifo_o_count   (fifo_o_count),
        .fifo_o_full    (fifo_o_full),
        .fifo_o_empty   (fifo_o_empty),
        .fifo_o_overflow(fifo_o_overflow)
    );

    always #5 clk = ~clk;

    // Behavioural model: lifecycle as an integer, contents as a queue.
    int            m_st;
    int            m_fgr;
    bit            m_abd;
    bit            m_ovf;
    logic [PW-1:0] q[$];

    int n_vec = 0;
    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic m_reset();
        m_st  = M_FREE;
        m_fgr = 0;
        m_abd = 1'b0;
        m_ovf = 1'b0;
        q.delete();
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic m_step();
        if (abandon_i_en && m_st != M_FREE && int'(abandon_i_fgr) == m_fgr) begin
            m_st  = M_FREE;
            m_abd = 1'b1;
            q.delete();
        end else begin
            case (m_st)
                M_FREE: if (alloc_i_en) begin
                    m_st  = M_OPEN;
                    m_fgr = int'(alloc_i_fgr);
                    m_abd = 1'b0;
                    m_ovf = 1'b0;
                    q.delete();
                end
                M_OPEN: begin
                    for (int k = 0; k < WP; k++) begin
                        if (push_i_wen[k]) begin
                            if (q.size() < DEPTH) q.push_back(push_i_prf[k*PW +: PW]);
                            else m_ovf = 1'b1;
                        end
                    end
                    if (seal_i_en) m_st = M_SEALED;
                end
                M_SEALED: if (commit_i_en && int'(commit_i_fgr) == m_fgr)
                    m_st = (q.size() == 0) ? M_FREE : M_DRAIN;
                M_DRAIN: if (pop_i_ren && q.size() > 0) begin
                    void'(q.pop_front());
                    if (q.size() == 0) m_st = M_FREE;
                end
                default: m_st = M_FREE;
            endcase
        end
    endtask

    task automatic compare_all();
        check("valid",     32'(tag_o_valid),     32'(m_st != M_FREE));
        check("open",      32'(tag_o_open),      32'(m_st == M_OPEN));
        check("sealed",    32'(tag_o_sealed),    32'(m_st == M_SEALED));
        check("drain",     32'(tag_o_drain),     32'(m_st == M_DRAIN));
        check("abandoned", 32'(tag_o_abandoned), 32'(m_abd));
        check("fgr",       32'(fgr_o),           32'(m_fgr));
        check("count",     32'(fifo_o_count),    32'(q.size()));
        check("full",      32'(fifo_o_full),     32'(q.size() == DEPTH));
        check("empty",     32'(fifo_o_empty),    32'(q.size() == 0));
        check("overflow",  32'(fifo_o_overflow), 32'(m_ovf));
        check("head_prf",  32'(fifo_o_prf),      (q.size() > 0) ? 32'(q[0]) : 32'd0);
    endtask

    task automatic idle();
        alloc_i_en    = 1'b0;
        alloc_i_fgr   = '0;
        push_i_wen    = '0;
        push_i_prf    = '0;
        seal_i_en     = 1'b0;
        commit_i_en   = 1'b0;
        commit_i_fgr  = '0;
        abandon_i_en  = 1'b0;
        abandon_i_fgr = '0;
        pop_i_ren     = 1'b0;
    endtask

    // Called at a falling edge with inputs set; returns at the next falling edge.
    task automatic tick();
        m_step();
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        compare_all();
        idle();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        m_reset();
        n_vec++;
        compare_all();
        @(negedge clk);
        compare_all();
        reset = 1'b1;
    endtask

    task automatic set_push(input logic [WP-1:0] wen, input logic [PW-1:0] p0,
                            input logic [PW-1:0] p1);
        push_i_wen = wen;
        push_i_prf = {p1, p0};
    endtask

    task automatic alloc(input int f);
        alloc_i_en = 1'b1; alloc_i_fgr = FW'(f); tick();
    endtask

    task automatic commit(input int f);
        commit_i_en = 1'b1; commit_i_fgr = FW'(f); tick();
    endtask

    task automatic abandon(input int f);
        abandon_i_en = 1'b1; abandon_i_fgr = FW'(f); tick();
    endtask

    task automatic seal();
        seal_i_en = 1'b1; tick();
    endtask

    task automatic pop();
        pop_i_ren = 1'b1; tick();
    endtask

    initial begin
        idle();
        m_reset();
        @(negedge clk);
        do_reset();

        // Fill and drain in order.
        alloc(5);
        set_push(2'b11, 6'h11, 6'h12); tick();
        set_push(2'b11, 6'h13, 6'h14); tick();
        check("lit_fill_count", 32'(fifo_o_count), 32'd4);
        check("lit_fill_full",  32'(fifo_o_full),  32'd1);
        seal();
        commit(5);
        check("lit_drain_state", 32'(tag_o_drain), 32'd1);
        check("lit_pop0", 32'(fifo_o_prf), 32'h11);
        pop(); check("lit_pop1", 32'(fifo_o_prf), 32'h12);
        pop(); check("lit_pop2", 32'(fifo_o_prf), 32'h13);
        pop(); check("lit_pop3", 32'(fifo_o_prf), 32'h14);
        pop(); check("lit_drain_free", 32'(tag_o_valid), 32'd0);

        // Overflow: only lane 0 fits.
        alloc(1);
        set_push(2'b11, 6'h30, 6'h31); tick();
        set_push(2'b01, 6'h32, 6'h3f); tick();
        set_push(2'b11, 6'h20, 6'h21); tick();
        check("lit_ovf_count", 32'(fifo_o_count),    32'd4);
        check("lit_ovf_flag",  32'(fifo_o_overflow), 32'd1);
        seal();
        commit(1);
        pop(); pop(); pop();
        check("lit_ovf_last", 32'(fifo_o_prf), 32'h20);
        pop();
        alloc(2);
        check("lit_ovf_clear", 32'(fifo_o_overflow), 32'd0);

        // FGR matching.
        set_push(2'b01, 6'h05, 6'h00); tick();
        seal();
        commit(3);
        check("lit_commit_mismatch", 32'(tag_o_sealed), 32'd1);
        abandon(3);
        check("lit_abandon_mismatch", 32'(tag_o_sealed), 32'd1);
        abandon(2);
        check("lit_abandon_valid", 32'(tag_o_valid),     32'd0);
        check("lit_abandon_flag",  32'(tag_o_abandoned), 32'd1);
        check("lit_abandon_count", 32'(fifo_o_count),    32'd0);

        // Priority: abandon beats seal and alloc; empty commit frees directly.
        alloc(6);
        check("lit_alloc_clears_abd", 32'(tag_o_abandoned), 32'd0);
        seal_i_en = 1'b1; alloc_i_en = 1'b1; alloc_i_fgr = 3'd6;
        abandon_i_en = 1'b1; abandon_i_fgr = 3'd6; tick();
        check("lit_prio_free", 32'(tag_o_valid),     32'd0);
        check("lit_prio_abd",  32'(tag_o_abandoned), 32'd1);
        alloc(7);
        seal();
        commit(7);
        check("lit_empty_commit_valid", 32'(tag_o_valid), 32'd0);
        check("lit_empty_commit_drain", 32'(tag_o_drain), 32'd0);

        // Reset mid-drain with three entries.
        alloc(4);
        set_push(2'b11, 6'h01, 6'h02); tick();
        set_push(2'b01, 6'h03, 6'h00); tick();
        seal();
        commit(4);
        check("lit_pre_reset_count", 32'(fifo_o_count), 32'd3);
        do_reset();
        check("lit_rst_valid", 32'(tag_o_valid),  32'd0);
        check("lit_rst_count", 32'(fifo_o_count), 32'd0);
        check("lit_rst_empty", 32'(fifo_o_empty), 32'd1);
        check("lit_rst_fgr",   32'(fgr_o),        32'd0);
        check("lit_rst_prf",   32'(fifo_o_prf),   32'd0);

        // Repeated rounds of three entries.
        for (int r = 0; r < 3; r++) begin
            logic [PW-1:0] b;
            b = PW'(8 * r + 8);
            alloc(r);
            set_push(2'b11, b, b + 6'd1); tick();
            set_push(2'b01, b + 6'd2, 6'h00); tick();
            seal();
            commit(r);
            for (int i = 0; i < 3; i++) begin
                check("lit_round_data", 32'(fifo_o_prf), 32'(b + PW'(i)));
                pop();
            end
            check("lit_round_free", 32'(tag_o_valid), 32'd0);
        end

        // Randomized run against the model.
        for (int it = 0; it < 4000; it++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                alloc_i_en    = 1'($urandom_range(0, 1));
                alloc_i_fgr   = FW'($urandom_range(0, 1));
                push_i_wen    = WP'($urandom);
                push_i_prf    = PRFW'($urandom);
                seal_i_en     = ($urandom_range(0, 3) == 0);
                commit_i_en   = ($urandom_range(0, 2) == 0);
                commit_i_fgr  = FW'($urandom_range(0, 1));
                abandon_i_en  = ($urandom_range(0, 15) == 0);
                abandon_i_fgr = FW'($urandom_range(0, 1));
                pop_i_ren     = ($urandom_range(0, 2) != 0);
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
